lda_mm_engine: RTL and testbench
================================

Name: lda_mm_engine

Overview:
Memory-mapped line-drawing accelerator for the Nios system.
- Avalon-MM slave register file plus a Bresenham engine that streams pixel writes to the VGA framebuffer writer over a valid/ready handshake.
- Generalises the fixed-resolution LDA interface: parametrised coordinate and colour widths, selectable stall or poll completion mode, pixel counter, and a per-pixel backpressure handshake.

Parameters:
X_W, 9, x coordinate width (1..16)
Y_W, 8, y coordinate width (1..16)
COLOR_W, 3, colour width (1..32)

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
avs_address  in  3  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, combinational, same cycle as read
avs_waitrequest  out  1  slave stall
pix_x  out  X_W  pixel x
pix_y  out  Y_W  pixel y
pix_color  out  COLOR_W  pixel colour
pix_valid  out  1  pixel available
pix_ready  in  1  downstream accepts pixel
busy  out  1  engine not IDLE

Behaviour:
Register map (word addresses):
- 0 MODE (rw): bit0, 0 = stall, 1 = poll.
- 1 STATUS (ro): bit0 = busy; bit1 = overrun, sticky, cleared on read.
- 2 GO (wo): any write starts a line.
- 3 START (rw): x in [X_W-1:0], y in [16+Y_W-1:16].
- 4 END (rw): same packing as START.
- 5 COLOR (rw): [COLOR_W-1:0].
- 6 PIXCOUNT (ro): pixels accepted in the current or last line, 32-bit.
- 7 reserved: reads 0, writes ignored.
- Unused read bits return 0.

Reset values:
- All registers 0; MODE = stall.
- State IDLE; pix_valid = 0, busy = 0, avs_waitrequest = 0, pix_x/pix_y/pix_color = 0, avs_readdata = 0.

FSM:
- IDLE -> INIT on accepted GO.
- INIT: latch START, END and COLOR into working regs; compute:
  - dx = |x1-x0|, dy = -|y1-y0|
  - sx/sy = step direction (+1 or -1)
  - err = dx+dy, signed width max(X_W,Y_W)+2
  - clear PIXCOUNT
- DRAW: pix_valid = 1 with current point.
  - On pix_valid && pix_ready: PIXCOUNT++.
  - If point == end -> DONE; else Bresenham step using e2 = 2*err (x step if e2 >= dy, y step if e2 <= dx, both allowed in one step).
- DONE: one cycle, pix_valid = 0 -> IDLE.

Timing and handshake:
- GO accepted in cycle N: INIT in N+1, first pix_valid in N+2.
- Throughput is one pixel per cycle while pix_ready is high.
- While pix_valid && !pix_ready, pix_x/pix_y/pix_color are held stable.
- A single-point line (start == end) emits exactly 1 pixel.
- Pixel count is max(|dx|,|dy|)+1.

Modes:
- Stall mode: a GO write holds avs_waitrequest = 1 from the cycle the write is presented until the DONE cycle; the write completes in DONE. Reads and writes of other registers are never stalled.
- Poll mode: GO completes immediately (waitrequest = 0). GO while busy is ignored and sets overrun.

Register writes while busy:
- START/END/COLOR writes are accepted and affect only the next line, since working copies were latched in INIT.
- MODE writes while busy take effect at the next GO.

Reset mid-draw:
- Reset asserted during DRAW: immediate IDLE, pix_valid = 0, a pending pixel is dropped, no partial completion.

Optional Feature:
Macro LDA_IRQ_EN.
- Defined: adds output irq (1 bit), level, set on DONE, cleared by reading STATUS; address 7 becomes IRQ_EN (bit0, rw, reset 0) and irq is gated by it.
- Undefined: no irq port; address 7 stays reserved.

Decomposition:
Shared package lda_pkg:
- register address constants (ADDR_MODE..ADDR_IRQ_EN)
- state enum (IDLE, INIT, DRAW, DONE)
- field offset constants (Y_LSB = 16)

Sub-module lda_bresenham_step:
- combinational next-point/next-err calculator
- inputs: point, err, dx, dy, sx, sy
- outputs: next point, next err
- instantiated once in the engine.

Test Plan:
- Poll mode, START = (0,0), END = (3,0), COLOR = 5, pix_ready = 1 -> pixels (0,0),(1,0),(2,0),(3,0) with colour 5 on 4 consecutive cycles starting 2 cycles after GO; PIXCOUNT = 4; busy low after DONE.
- Steep reverse line START = (2,5), END = (0,0) -> pixels (2,5),(2,4),(1,3),(1,2),(0,1),(0,0); PIXCOUNT = 6.
- Backpressure: pix_ready toggled 1,0,0,1 on line (0,0)-(2,2) -> each pixel held stable while stalled; pixels (0,0),(1,1),(2,2) each accepted exactly once; PIXCOUNT = 3.
- Stall mode, line (0,0)-(4,1) -> avs_waitrequest high from GO presentation through the DONE cycle; 5 pixels emitted; a STATUS read after completion returns busy = 0.
- Poll mode, second GO while busy -> second GO ignored; STATUS reads 0x3, then 0x1 (or 0x0 if finished) on the next read; line completes unchanged.
- Reset asserted in DRAW after 2 of 8 pixels -> pix_valid low and busy low while reset is asserted; registers at reset values; a new GO afterwards draws normally from START = (0,0).

Source files
------------

// File: rtl/lda_mm_engine_pkg.sv
// Shared definitions for the line-drawing accelerator: register map, engine
// states and register field offsets.
package lda_pkg;

  localparam logic [2:0] ADDR_MODE     = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
  localparam logic [2:0] ADDR_GO       = 3'd2;
  localparam logic [2:0] ADDR_START    = 3'd3;
  localparam logic [2:0] ADDR_END      = 3'd4;
  localparam logic [2:0] ADDR_COLOR    = 3'd5;
  localparam logic [2:0] ADDR_PIXCOUNT = 3'd6;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd7;

  localparam int Y_LSB = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lda_mm_engine_if.sv
// Avalon-MM slave bus plus the pixel stream to the framebuffer writer.
// The engine uses the slave modport; the bus master / pixel sink uses master.
interface lda_mm_engine_if #(
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 3
);
  logic [2:0]         avs_address;
  logic               avs_read;
  logic               avs_write;
  logic [31:0]        avs_writedata;
  logic [31:0]        avs_readdata;
  logic               avs_waitrequest;
  logic [X_W-1:0]     pix_x;
  logic [Y_W-1:0]     pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_valid;
  logic               pix_ready;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, pix_ready,
    output avs_readdata, avs_waitrequest, pix_x, pix_y, pix_color, pix_valid
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, pix_ready,
    input  avs_readdata, avs_waitrequest, pix_x, pix_y, pix_color, pix_valid
  );
endinterface

// File: rtl/lda_mm_engine_step.sv
// Combinational Bresenham step: from the current point and error term, the
// next point and error. Both axes may step in the same cycle.
module lda_bresenham_step #(
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int EW  = 11
) (
  input  logic [X_W-1:0]       cur_x,
  input  logic [Y_W-1:0]       cur_y,
  input  logic signed [EW-1:0] err,
  input  logic signed [EW-1:0] dx,
  input  logic signed [EW-1:0] dy,
  input  logic                 sx_neg,
  input  logic                 sy_neg,
  output logic [X_W-1:0]       nxt_x,
  output logic [Y_W-1:0]       nxt_y,
  output logic signed [EW-1:0] nxt_err
);

  logic signed [EW:0] e2;
  logic signed [EW:0] dx_w;
  logic signed [EW:0] dy_w;
  logic signed [EW:0] acc;
  logic               step_x;
  logic               step_y;

  always_comb begin
    e2     = {err, 1'b0};
    dx_w   = {dx[EW-1], dx};
    dy_w   = {dy[EW-1], dy};
    step_x = (e2 >= dy_w);
    step_y = (e2 <= dx_w);
    acc    = {err[EW-1], err};
    if (step_x) acc = acc + dy_w;
    if (step_y) acc = acc + dx_w;
    nxt_err = acc[EW-1:0];
    nxt_x   = cur_x;
    nxt_y   = cur_y;
    if (step_x) nxt_x = sx_neg ? cur_x - X_W'(1) : cur_x + X_W'(1);
    if (step_y) nxt_y = sy_neg ? cur_y - Y_W'(1) : cur_y + Y_W'(1);
  end

endmodule

// File: rtl/lda_mm_engine.sv
// Memory-mapped line-drawing accelerator: register file plus Bresenham engine
// streaming pixels over valid/ready. Define LDA_IRQ_EN for the irq output.
module lda_mm_engine
  import lda_pkg::*;
#(
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 3
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  lda_mm_engine_if.slave  bus,
`ifdef LDA_IRQ_EN
  output logic            irq,
`endif
  output logic            busy
);

  // state | meaning
  // IDLE  | waiting for GO
  // INIT  | latch endpoints/colour, set up dx/dy/err, clear PIXCOUNT
  // DRAW  | present current point; advance on accepted pixel
  // DONE  | one-cycle completion, releases a stalled GO write

  localparam int EW = max2(X_W, Y_W) + 2;

  state_e state_q, state_d;

  logic               mode_q;
  logic               run_stall_q;
  logic               overrun_q;
  logic [31:0]        pixcount_q;
  logic [X_W-1:0]     start_x_q, end_x_q, cur_x_q, tgt_x_q;
  logic [Y_W-1:0]     start_y_q, end_y_q, cur_y_q, tgt_y_q;
  logic [COLOR_W-1:0] color_q, col_q;
  logic signed [EW-1:0] dx_q, dy_q, err_q;
  logic               sx_q, sy_q;

  logic               wr_go, go_stall_sel, waitreq, wr_ok;
  logic               go_acc, overrun_set, rd_status, at_end, pix_valid;
  logic [31:0]        rdata;
  logic               x_neg, y_neg;
  logic [X_W-1:0]     adx, nxt_x;
  logic [Y_W-1:0]     ady, nxt_y;
  logic signed [EW-1:0] dx_init, dy_init, nxt_err;
  logic               unused_wdata;

  assign unused_wdata = ^bus.avs_writedata;

  assign busy   = (state_q != IDLE);
  assign wr_go  = bus.avs_write && (bus.avs_address == ADDR_GO);
  // A GO in IDLE follows the current MODE; once running it follows the mode latched at GO.
  assign go_stall_sel = (state_q == IDLE) ? !mode_q : run_stall_q;
  assign waitreq      = wr_go && go_stall_sel && (state_q != DONE);
  assign wr_ok        = bus.avs_write && !waitreq;
  assign go_acc       = wr_go && (state_q == IDLE);
  assign overrun_set  = wr_go && (state_q != IDLE) && !run_stall_q;
  assign rd_status    = bus.avs_read && (bus.avs_address == ADDR_STATUS);
  assign at_end       = (cur_x_q == tgt_x_q) && (cur_y_q == tgt_y_q);

  always_comb begin
    x_neg   = (end_x_q < start_x_q);
    y_neg   = (end_y_q < start_y_q);
    adx     = x_neg ? (start_x_q - end_x_q) : (end_x_q - start_x_q);
    ady     = y_neg ? (start_y_q - end_y_q) : (end_y_q - start_y_q);
    dx_init = {{(EW-X_W){1'b0}}, adx};
    dy_init = -{{(EW-Y_W){1'b0}}, ady};
  end

  lda_bresenham_step #(.X_W(X_W), .Y_W(Y_W), .EW(EW)) u_step (
    .cur_x   (cur_x_q),
    .cur_y   (cur_y_q),
    .err     (err_q),
    .dx      (dx_q),
    .dy      (dy_q),
    .sx_neg  (sx_q),
    .sy_neg  (sy_q),
    .nxt_x   (nxt_x),
    .nxt_y   (nxt_y),
    .nxt_err (nxt_err)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pix_valid = 1'b0;
    case (state_q)
      IDLE: if (go_acc) state_d = INIT;
      INIT: state_d = DRAW;
      DRAW: begin
        pix_valid = 1'b1;
        if (bus.pix_ready && at_end) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mode_q    <= 1'b0;
      start_x_q <= '0;
      start_y_q <= '0;
      end_x_q   <= '0;
      end_y_q   <= '0;
      color_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        case (bus.avs_address)
          ADDR_MODE:  mode_q <= bus.avs_writedata[0];
          ADDR_START: begin
            start_x_q <= bus.avs_writedata[X_W-1:0];
            start_y_q <= bus.avs_writedata[Y_LSB +: Y_W];
          end
          ADDR_END: begin
            end_x_q <= bus.avs_writedata[X_W-1:0];
            end_y_q <= bus.avs_writedata[Y_LSB +: Y_W];
          end
          ADDR_COLOR: color_q <= bus.avs_writedata[COLOR_W-1:0];
          default: ;
        endcase
      end
      if (overrun_set)    overrun_q <= 1'b1;
      else if (rd_status) overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      run_stall_q <= 1'b0;
      pixcount_q  <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      tgt_x_q     <= '0;
      tgt_y_q     <= '0;
      col_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
    end else begin
      if (go_acc) run_stall_q <= !mode_q;
      if (state_q == INIT) begin
        cur_x_q    <= start_x_q;
        cur_y_q    <= start_y_q;
        tgt_x_q    <= end_x_q;
        tgt_y_q    <= end_y_q;
        col_q      <= color_q;
        dx_q       <= dx_init;
        dy_q       <= dy_init;
        err_q      <= dx_init + dy_init;
        sx_q       <= x_neg;
        sy_q       <= y_neg;
        pixcount_q <= '0;
      end else if (state_q == DRAW && bus.pix_ready) begin
        pixcount_q <= pixcount_q + 32'd1;
        if (!at_end) begin
          cur_x_q <= nxt_x;
          cur_y_q <= nxt_y;
          err_q   <= nxt_err;
        end
      end
    end
  end

`ifdef LDA_IRQ_EN
  logic irq_en_q, irq_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ok && bus.avs_address == ADDR_IRQ_EN) irq_en_q <= bus.avs_writedata[0];
      if (state_q == DONE) irq_q <= 1'b1;
      else if (rd_status)  irq_q <= 1'b0;
    end
  end

  assign irq = irq_q & irq_en_q;
`endif

  always_comb begin
    rdata = '0;
    if (bus.avs_read) begin
      case (bus.avs_address)
        ADDR_MODE:   rdata[0] = mode_q;
        ADDR_STATUS: rdata[1:0] = {overrun_q, busy};
        ADDR_START: begin
          rdata[X_W-1:0]       = start_x_q;
          rdata[Y_LSB +: Y_W]  = start_y_q;
        end
        ADDR_END: begin
          rdata[X_W-1:0]       = end_x_q;
          rdata[Y_LSB +: Y_W]  = end_y_q;
        end
        ADDR_COLOR:    rdata[COLOR_W-1:0] = color_q;
        ADDR_PIXCOUNT: rdata = pixcount_q;
`ifdef LDA_IRQ_EN
        ADDR_IRQ_EN:   rdata[0] = irq_en_q;
`endif
        default: rdata = '0;
      endcase
    end
  end

  assign bus.avs_readdata    = rdata;
  assign bus.avs_waitrequest = waitreq;
  assign bus.pix_valid       = pix_valid;
  assign bus.pix_x           = cur_x_q;
  assign bus.pix_y           = cur_y_q;
  assign bus.pix_color       = col_q;

endmodule

// File: tb/tb_lda_mm_engine.sv
// Directed bench for lda_mm_engine: register access, line shapes, pixel
// backpressure, stall/poll completion, overrun and reset during a line.
module tb_lda_mm_engine;
  import lda_pkg::*;

  localparam int X_W     = 9;
  localparam int Y_W     = 8;
  localparam int COLOR_W = 3;
  localparam int LIM     = 200;

  logic clk_clk       = 1'b0;
  logic reset_reset_n = 1'b0;
  logic busy;
`ifdef LDA_IRQ_EN
  logic irq;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int px_q[$];
  int pc_q[$];
  int exp_q[$];

  logic prev_stall = 1'b0;
  int   prev_px    = 0;

  lda_mm_engine_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) bus ();

  lda_mm_engine #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bus           (bus),
`ifdef LDA_IRQ_EN
    .irq           (irq),
`endif
    .busy          (busy)
  );

  always #5 clk_clk = ~clk_clk;

  always @(posedge clk_clk) cyc <= cyc + 1;

  function automatic int pk(input int x, input int y, input int c);
    return (c << 17) | (y << 9) | x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pixel sink monitor: records accepted pixels and checks stalled pixels hold.
  always @(negedge clk_clk) begin
    if (reset_reset_n) begin
      if (prev_stall) begin
        chk("hold_px", pk(bus.pix_x, bus.pix_y, bus.pix_color), prev_px);
        chk("hold_vld", bus.pix_valid, 1);
      end
      if (bus.pix_valid && bus.pix_ready) begin
        px_q.push_back(pk(bus.pix_x, bus.pix_y, bus.pix_color));
        pc_q.push_back(cyc);
      end
      prev_stall <= bus.pix_valid && !bus.pix_ready;
      prev_px    <= pk(bus.pix_x, bus.pix_y, bus.pix_color);
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d,
                           output int waits, output int acc);
    int n = 0;
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge clk_clk);
    while (bus.avs_waitrequest && n < LIM) begin
      @(negedge clk_clk);
      n++;
    end
    if (n >= LIM) chk("wr_timeout", n, 0);
    waits = n;
    acc   = cyc;
    @(posedge clk_clk);
    #1;
    bus.avs_write = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    int w, c;
    bus_write(a, d, w, c);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk_clk);
    d = bus.avs_readdata;
    @(posedge clk_clk);
    #1;
    bus.avs_read = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk_clk);
    while (busy && n < LIM) begin
      @(negedge clk_clk);
      n++;
    end
    if (n >= LIM) chk({tag, "_timeout"}, n, 0);
    @(posedge clk_clk);
    #1;
  endtask

  task automatic expx(input int x, input int y, input int c);
    exp_q.push_back(pk(x, y, c));
  endtask

  task automatic clear_q();
    px_q.delete();
    pc_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_line(input string tag);
    chk({tag, "_npix"}, px_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < px_q.size(); i++)
      chk($sformatf("%s_px%0d", tag, i), px_q[i], exp_q[i]);
  endtask

  initial begin
    int w, acc, acc2;
    logic [3:0] pat;

    bus.avs_address   = '0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    bus.pix_ready     = 1'b1;

    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk);
    chk("rst_valid", bus.pix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wait", bus.avs_waitrequest, 0);
    chk("rst_rdata", bus.avs_readdata, 0);
    chk("rst_pix", pk(bus.pix_x, bus.pix_y, bus.pix_color), 0);
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;

    rd_chk("rst_mode", ADDR_MODE, 0);
    rd_chk("rst_start", ADDR_START, 0);
    rd_chk("rst_pixcnt", ADDR_PIXCOUNT, 0);
    rd_chk("rsvd7", 3'd7, 0);
    wr(ADDR_COLOR, 32'hFFFF_FFFF);
    rd_chk("color_mask", ADDR_COLOR, 32'h7);
    wr(ADDR_END, 32'hFFFF_FFFF);
    rd_chk("end_mask", ADDR_END, 32'h00FF_01FF);

    // Horizontal line, poll mode
    wr(ADDR_MODE, 1);
    rd_chk("mode_rb", ADDR_MODE, 1);
    wr(ADDR_START, 32'h0000_0000);
    wr(ADDR_END, 32'h0000_0003);
    wr(ADDR_COLOR, 5);
    clear_q();
    bus_write(ADDR_GO, 0, w, acc);
    chk("h_go_wait", w, 0);
    wait_idle("h");
    expx(0, 0, 5); expx(1, 0, 5); expx(2, 0, 5); expx(3, 0, 5);
    chk_line("h");
    if (pc_q.size() == 4) begin
      chk("h_first_cyc", pc_q[0], acc + 2);
      chk("h_last_cyc", pc_q[3], acc + 5);
    end
    rd_chk("h_pixcnt", ADDR_PIXCOUNT, 4);
    rd_chk("h_status", ADDR_STATUS, 0);

    // Steep reverse line
    wr(ADDR_START, 32'h0005_0002);
    wr(ADDR_END, 32'h0000_0000);
    wr(ADDR_COLOR, 6);
    clear_q();
    wr(ADDR_GO, 0);
    wait_idle("s");
    expx(2, 5, 6); expx(2, 4, 6); expx(1, 3, 6);
    expx(1, 2, 6); expx(0, 1, 6); expx(0, 0, 6);
    chk_line("s");
    rd_chk("s_pixcnt", ADDR_PIXCOUNT, 6);

    // Diagonal with backpressure pattern 1,0,0,1
    wr(ADDR_START, 32'h0000_0000);
    wr(ADDR_END, 32'h0002_0002);
    wr(ADDR_COLOR, 2);
    clear_q();
    bus_write(ADDR_GO, 0, w, acc);
    pat = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_clk);
      #1;
      bus.pix_ready = pat[3-i];
    end
    @(posedge clk_clk);
    #1;
    bus.pix_ready = 1'b1;
    wait_idle("bp");
    expx(0, 0, 2); expx(1, 1, 2); expx(2, 2, 2);
    chk_line("bp");
    if (pc_q.size() == 3) chk("bp_acc2_cyc", pc_q[1], acc + 5);
    rd_chk("bp_pixcnt", ADDR_PIXCOUNT, 3);

    // Stall mode: GO write held until DONE
    wr(ADDR_MODE, 0);
    wr(ADDR_END, 32'h0001_0004);
    wr(ADDR_COLOR, 3);
    clear_q();
    bus_write(ADDR_GO, 0, w, acc);
    chk("st_waits", w, 7);
    expx(0, 0, 3); expx(1, 0, 3); expx(2, 1, 3); expx(3, 1, 3); expx(4, 1, 3);
    chk_line("st");
    if (pc_q.size() == 5) chk("st_first_cyc", pc_q[0], acc - 5);
    rd_chk("st_status", ADDR_STATUS, 0);
    rd_chk("st_pixcnt", ADDR_PIXCOUNT, 5);

    // Poll mode overrun: second GO while busy is ignored
    wr(ADDR_MODE, 1);
    wr(ADDR_END, 32'h0000_0005);
    wr(ADDR_COLOR, 1);
    clear_q();
    bus_write(ADDR_GO, 0, w, acc);
    bus_write(ADDR_GO, 0, w, acc2);
    chk("ov_go2_wait", w, 0);
    rd_chk("ov_status1", ADDR_STATUS, 3);
    rd_chk("ov_status2", ADDR_STATUS, 1);
    wait_idle("ov");
    expx(0, 0, 1); expx(1, 0, 1); expx(2, 0, 1);
    expx(3, 0, 1); expx(4, 0, 1); expx(5, 0, 1);
    chk_line("ov");
    rd_chk("ov_status3", ADDR_STATUS, 0);
    rd_chk("ov_pixcnt", ADDR_PIXCOUNT, 6);

    // Reset in the middle of an 8-pixel line
    wr(ADDR_END, 32'h0000_0007);
    clear_q();
    bus_write(ADDR_GO, 0, w, acc);
    repeat (3) @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    chk("mr_valid", bus.pix_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_npix", px_q.size(), 2);
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    rd_chk("mr_mode", ADDR_MODE, 0);
    rd_chk("mr_end", ADDR_END, 0);
    rd_chk("mr_color", ADDR_COLOR, 0);
    rd_chk("mr_pixcnt", ADDR_PIXCOUNT, 0);
    clear_q();
    bus_write(ADDR_GO, 0, w, acc);
    chk("mr_waits", w, 3);
    expx(0, 0, 0);
    chk_line("mr");
    rd_chk("mr_pixcnt2", ADDR_PIXCOUNT, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
